// File: rtl/comparator_pkg.sv
// comparator_pkg: shared types and constants for the comparator self-test
package comparator_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
  localparam logic [2:0] REL_GT = 3'b100;
  localparam logic [2:0] REL_LT = 3'b010;
  localparam logic [2:0] REL_EQ = 3'b001;
  localparam int ERRW = 16;
endpackage

// File: rtl/cmp_expect_pipe.sv
// cmp_expect_pipe: LAT-deep delay line keeping expected results aligned with the DUT response
module cmp_expect_pipe #(
  parameter int W = 12,
  parameter int LAT = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  if (LAT == 0) begin : g_thru
    logic unused_clk;
    assign unused_clk = clk ^ rst_n;
    assign q_o = d_i;
  end else begin : g_sr
    logic [W-1:0] sr_q [LAT];
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) for (int i = 0; i < LAT; i++) sr_q[i] <= '0;
      else begin
        sr_q[0] <= d_i;
        for (int i = 1; i < LAT; i++) sr_q[i] <= sr_q[i-1];
      end
    assign q_o = sr_q[LAT-1];
  end
endmodule

// File: rtl/comparator_4bit_bist.sv
// comparator_4bit_bist: exhaustive operand sweep driver and result checker for a magnitude comparator
module comparator_4bit_bist
  import comparator_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int LAT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  input  logic             greater_i,
  input  logic             less_i,
  input  logic             equal_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERRW-1:0]  err_count,
  output logic             first_err_valid,
  output logic [WIDTH-1:0] first_err_a,
  output logic [WIDTH-1:0] first_err_b
);
  localparam int CW = 2 * WIDTH;
  localparam int PW = 1 + CW + 3;
  localparam int DW = LAT > 0 ? $clog2(LAT + 1) : 1;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, fe_q, fe_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [ERRW-1:0] err_q, err_d;
  logic pass_q, pass_d, fe_vld_q, fe_vld_d;
  logic [2:0] exp_now, chk_exp;
  logic [PW-1:0] pipe_in, pipe_out;
  logic chk_vld, mism;
  logic [CW-1:0] chk_ab;
  assign a_o = cnt_q[CW-1:WIDTH];
  assign b_o = cnt_q[WIDTH-1:0];
  assign exp_now = a_o > b_o ? REL_GT : a_o < b_o ? REL_LT : REL_EQ;
  // valid tag marks the cycles that carry a real vector, so DRAIN/IDLE slots are never checked
  assign pipe_in = {state_q == RUN, cnt_q, exp_now};
  cmp_expect_pipe #(.W(PW), .LAT(LAT)) u_pipe (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (pipe_in),
    .q_o  (pipe_out)
  );
  assign {chk_vld, chk_ab, chk_exp} = pipe_out;
  assign mism = chk_vld && ({greater_i, less_i, equal_i} != chk_exp);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    dcnt_d = dcnt_q;
    err_d = err_q;
    pass_d = pass_q;
    fe_vld_d = fe_vld_q;
    fe_d = fe_q;
    if (mism) begin
      err_d = &err_q ? err_q : err_q + 1'b1;
      fe_vld_d = 1'b1;
      fe_d = fe_vld_q ? fe_q : chk_ab;
    end
    case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        cnt_d = '0;
        err_d = '0;
        pass_d = 1'b0;
        fe_vld_d = 1'b0;
        fe_d = '0;
      end
      RUN: if (&cnt_q) begin
        state_d = LAT > 0 ? DRAIN : DONE;
        dcnt_d = '0;
      end else cnt_d = cnt_q + 1'b1;
      DRAIN: if (dcnt_q == DW'(LAT - 1)) state_d = DONE;
        else dcnt_d = dcnt_q + 1'b1;
      default: state_d = IDLE;
    endcase
    // the final check lands on the same edge that enters DONE, so judge from err_d
    if (state_d == DONE && state_q != DONE) pass_d = err_d == '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      dcnt_q <= '0;
      err_q <= '0;
      pass_q <= 1'b0;
      fe_vld_q <= 1'b0;
      fe_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      dcnt_q <= dcnt_d;
      err_q <= err_d;
      pass_q <= pass_d;
      fe_vld_q <= fe_vld_d;
      fe_q <= fe_d;
    end
  assign busy = state_q == RUN || state_q == DRAIN;
  assign done = state_q == DONE;
  assign pass = pass_q;
  assign err_count = err_q;
  assign first_err_valid = fe_vld_q;
  assign first_err_a = fe_q[CW-1:WIDTH];
  assign first_err_b = fe_q[WIDTH-1:0];
endmodule

// File: tb/tb_comparator_4bit_bist.sv
// tb_comparator_4bit_bist: drives two BIST instances (LAT=0, LAT=2) against good and faulty comparators
module tb_comparator_4bit_bist;
  logic clk = 1'b0, rst_n = 1'b0, start0 = 1'b0, start2 = 1'b0;
  always #5 clk = ~clk;
  logic [3:0] a0, b0, a2, b2, fa0, fb0, fa2, fb2;
  logic g0, l0, e0, g2, l2, e2, busy0, done0, pass0, fv0, busy2, done2, pass2, fv2;
  logic [15:0] err0, err2;
  logic [2:0] c0, r0, d1, d2, f1, f2;
  logic [2:0] fault_tab [256];
  int mode = 0, idle0 = 0, checks = 0, failures = 0;
  int done_cyc, ndone, nbusy, bfirst, blast;
  logic pass_at_done;
  int m_err;
  logic [3:0] m_fa, m_fb;
  logic m_fv;

  function automatic logic [2:0] rel(input int a, input int b);
    return a > b ? 3'b100 : a < b ? 3'b010 : 3'b001;
  endfunction

  // device under test: good comparator with optional injected faults or two output registers
  always_comb begin
    c0 = rel(int'(a0), int'(b0));
    case (mode)
      1: r0 = c0 & 3'b110;
      2: r0 = {c0[1], c0[2], c0[0]};
      3: r0 = 3'b000;
      4: r0 = c0 ^ fault_tab[{a0, b0}];
      5: r0 = d2;
      default: r0 = c0;
    endcase
  end
  assign {g0, l0, e0} = r0;
  assign {g2, l2, e2} = f2;
  always_ff @(posedge clk) begin
    d1 <= rel(int'(a0), int'(b0));
    d2 <= d1;
    f1 <= rel(int'(a2), int'(b2));
    f2 <= f1;
  end

  comparator_4bit_bist #(.WIDTH(4), .LAT(0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .a_o(a0), .b_o(b0),
    .greater_i(g0), .less_i(l0), .equal_i(e0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .first_err_valid(fv0), .first_err_a(fa0), .first_err_b(fb0));
  comparator_4bit_bist #(.WIDTH(4), .LAT(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a_o(a2), .b_o(b2),
    .greater_i(g2), .less_i(l2), .equal_i(e2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .first_err_valid(fv2), .first_err_a(fa2), .first_err_b(fb2));

  // whole-sweep reference: what the DUT answers for each vector versus the true relation
  function automatic void model(input int md, input int lag, input int prev);
    int src;
    logic [2:0] want, got;
    m_err = 0; m_fv = 1'b0; m_fa = '0; m_fb = '0;
    for (int k = 0; k < 256; k++) begin
      src = k - lag < 0 ? prev : k - lag;
      want = rel(k / 16, k % 16);
      got = rel(src / 16, src % 16);
      case (md)
        1: got[0] = 1'b0;
        2: got = {got[1], got[2], got[0]};
        3: got = 3'b000;
        4: got = got ^ fault_tab[k];
        default: ;
      endcase
      if (got != want) begin
        if (m_err < 65535) m_err++;
        if (!m_fv) begin m_fv = 1'b1; m_fa = 4'(k / 16); m_fb = 4'(k % 16); end
      end
    end
  endfunction

  task automatic sweep(input bit sel, input int s1, input int s2, input int s3, input int fc);
    logic b, d;
    int lat;
    lat = sel ? 2 : 0;
    done_cyc = -1; ndone = 0; nbusy = 0; bfirst = -1; blast = -1; pass_at_done = 1'bx;
    @(negedge clk);
    if (sel) start2 = 1'b1; else start0 = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 263 + lat; c++) begin
      @(negedge clk);
      start0 = !sel && (c == s1 || c == s2 || c == s3);
      start2 = sel && (c == s1 || c == s2 || c == s3);
      if (c == fc) force u0.err_q = 16'hFFF0;
      if (c == fc + 1) release u0.err_q;
      b = sel ? busy2 : busy0;
      d = sel ? done2 : done0;
      if (b) begin nbusy++; if (bfirst < 0) bfirst = c; blast = c; end
      if (d) begin ndone++; if (done_cyc < 0) begin done_cyc = c; pass_at_done = sel ? pass2 : pass0; end end
    end
    start0 = 1'b0; start2 = 1'b0;
    if (!sel) idle0 = 255;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({a0, b0} !== 8'h00) begin failures++; $display("FAIL reset_ab got=%h want=00", {a0, b0}); end
    checks++; if ({busy0, done0, pass0, fv0} !== 4'b0) begin failures++; $display("FAIL reset_flags got=%b want=0000", {busy0, done0, pass0, fv0}); end
    checks++; if (err0 !== 16'h0) begin failures++; $display("FAIL reset_err got=%h want=0000", err0); end
    checks++; if ({fa0, fb0} !== 8'h00) begin failures++; $display("FAIL reset_first got=%h want=00", {fa0, fb0}); end
    checks++; if ({busy2, done2, pass2, fv2, err2} !== 20'h0) begin failures++; $display("FAIL reset_lat2 got=%h want=0", {busy2, done2, pass2, fv2, err2}); end
    @(negedge clk);
    rst_n = 1'b1;
    idle0 = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_correct;
    mode = 0;
    sweep(1'b0, -1, -1, -1, -1);
    checks++; if (done_cyc != 257) begin failures++; $display("FAIL good_done_cycle got=%0d want=257", done_cyc); end
    checks++; if (ndone != 1) begin failures++; $display("FAIL good_done_count got=%0d want=1", ndone); end
    checks++; if (nbusy != 256 || bfirst != 1 || blast != 256) begin failures++; $display("FAIL good_busy got=%0d/%0d..%0d want=256/1..256", nbusy, bfirst, blast); end
    checks++; if (pass_at_done !== 1'b1 || pass0 !== 1'b1) begin failures++; $display("FAIL good_pass got=%b/%b want=1/1", pass_at_done, pass0); end
    checks++; if (err0 !== 16'h0 || fv0 !== 1'b0) begin failures++; $display("FAIL good_err got=%h,%b want=0000,0", err0, fv0); end
  endtask

  task automatic test_fault(input int md, input string nm);
    mode = md;
    model(md, md == 5 ? 2 : 0, idle0);
    sweep(1'b0, -1, -1, -1, -1);
    checks++; if (err0 !== m_err[15:0]) begin failures++; $display("FAIL %s_err got=%0d want=%0d", nm, err0, m_err); end
    checks++; if (pass0 !== (m_err == 0)) begin failures++; $display("FAIL %s_pass got=%b want=%b", nm, pass0, m_err == 0); end
    checks++; if ({fv0, fa0, fb0} !== {m_fv, m_fa, m_fb}) begin failures++; $display("FAIL %s_first got=%b,%h,%h want=%b,%h,%h", nm, fv0, fa0, fb0, m_fv, m_fa, m_fb); end
    checks++; if (done_cyc != 257 || ndone != 1) begin failures++; $display("FAIL %s_done got=%0d x%0d want=257 x1", nm, done_cyc, ndone); end
  endtask

  task automatic test_lat2;
    sweep(1'b1, -1, -1, -1, -1);
    checks++; if (done_cyc != 259 || ndone != 1) begin failures++; $display("FAIL lat2_done got=%0d x%0d want=259 x1", done_cyc, ndone); end
    checks++; if (nbusy != 258 || bfirst != 1 || blast != 258) begin failures++; $display("FAIL lat2_busy got=%0d/%0d..%0d want=258/1..258", nbusy, bfirst, blast); end
    checks++; if (pass2 !== 1'b1 || err2 !== 16'h0 || fv2 !== 1'b0) begin failures++; $display("FAIL lat2_pass got=%b,%h,%b want=1,0000,0", pass2, err2, fv2); end
  endtask

  task automatic test_reset_mid;
    mode = 2;
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 101; c++) begin @(negedge clk); start0 = 1'b0; end
    checks++; if ({a0, b0} !== 8'h64) begin failures++; $display("FAIL mid_vector got=%h want=64", {a0, b0}); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if ({a0, b0, fa0, fb0} !== 16'h0 || err0 !== 16'h0) begin failures++; $display("FAIL mid_clear_data got=%h,%h want=0,0", {a0, b0, fa0, fb0}, err0); end
    checks++; if ({busy0, done0, pass0, fv0} !== 4'b0) begin failures++; $display("FAIL mid_clear_flags got=%b want=0000", {busy0, done0, pass0, fv0}); end
    @(negedge clk);
    rst_n = 1'b1;
    idle0 = 0;
    ndone = 0;
    for (int c = 0; c < 300; c++) begin @(negedge clk); if (done0) ndone++; end
    checks++; if (ndone != 0) begin failures++; $display("FAIL mid_no_done got=%0d want=0", ndone); end
    mode = 0;
    sweep(1'b0, -1, -1, -1, -1);
    checks++; if (pass0 !== 1'b1 || err0 !== 16'h0 || done_cyc != 257) begin failures++; $display("FAIL mid_restart got=%b,%h,%0d want=1,0000,257", pass0, err0, done_cyc); end
  endtask

  task automatic fill_faults;
    for (int k = 0; k < 256; k++)
      fault_tab[k] = $urandom_range(0, 7) == 0 ? 3'($urandom_range(1, 7)) : 3'b000;
  endtask

  task automatic test_random;
    for (int it = 0; it < 3; it++) begin
      fill_faults();
      repeat ($urandom_range(2, 10)) @(negedge clk);
      test_fault(4, "rand");
    end
  endtask

  task automatic test_back_to_back;
    mode = 4;
    fill_faults();
    model(4, 0, idle0);
    sweep(1'b0, 50, 256, 257, -1);
    checks++; if (ndone != 1 || done_cyc != 257) begin failures++; $display("FAIL b2b_done got=%0d x%0d want=257 x1", done_cyc, ndone); end
    checks++; if (nbusy != 256) begin failures++; $display("FAIL b2b_busy got=%0d want=256", nbusy); end
    checks++; if (err0 !== m_err[15:0]) begin failures++; $display("FAIL b2b_err got=%0d want=%0d", err0, m_err); end
  endtask

  task automatic test_saturate;
    mode = 3;
    sweep(1'b0, -1, -1, -1, 100);
    checks++; if (err0 !== 16'hFFFF) begin failures++; $display("FAIL sat_err got=%h want=ffff", err0); end
    checks++; if (pass0 !== 1'b0 || fv0 !== 1'b1) begin failures++; $display("FAIL sat_pass got=%b,%b want=0,1", pass0, fv0); end
  endtask

  initial begin
    test_reset();
    test_correct();
    test_fault(1, "eq_stuck");
    test_fault(2, "swap");
    test_lat2();
    test_fault(5, "wrap_lat0");
    test_reset_mid();
    test_random();
    test_back_to_back();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
